// File: rtl/pipeline_fetch_queue_pkg.sv
// pipeline_fetch_queue_pkg
//   Shared definitions for the fetch-to-decode instruction queue:
//   - default PC / instruction widths (match the system address/data buses)
//   - q_op_e: the per-cycle queue operation derived from push/pop
//   - decode_op(): maps the push/pop pair onto q_op_e
package pipeline_fetch_queue_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DEPTH      = 4;

    // Encoding is {push, pop} so decode_op() is a plain cast.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } q_op_e;

    function automatic q_op_e decode_op(input logic push, input logic pop);
        return q_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/pipeline_fetch_queue.sv
// pipeline_fetch_queue
//   DEPTH-entry circular instruction queue between fetch and decode.
//   Each entry holds {pc, inst, bubble}. Valid/ready handshake on both sides;
//   flush or global_flush empties the queue on the next clock edge.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush, global_flush   redirect / exception flush (identical effect)
//   in_valid, in_ready    fetch-side handshake
//   pc_in, inst_in, bubble_in   incoming entry
//   out_valid, out_ready  decode-side handshake
//   pc_out, inst_out, bubble_out head entry, forced to 0 when empty
//   count                 number of occupied entries
import pipeline_fetch_queue_pkg::*;

module pipeline_fetch_queue #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         global_flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_WIDTH-1:0]        pc_in,
    input  logic [DATA_WIDTH-1:0]        inst_in,
    input  logic                         bubble_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_WIDTH-1:0]        pc_out,
    output logic [DATA_WIDTH-1:0]        inst_out,
    output logic                         bubble_out,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    // Storage: plain register array, contents are never reset.
    logic [ADDR_WIDTH-1:0] pc_mem     [DEPTH];
    logic [DATA_WIDTH-1:0] inst_mem   [DEPTH];
    logic                  bubble_mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic flush_any;
    logic push;
    logic pop;
    q_op_e op;

    // in_ready looks only at registered state: a full queue refuses an entry
    // even when decode pops in the same cycle, keeping fetch off the decode
    // stall path.
    assign in_ready  = (count_reg != FULL_COUNT);
    assign out_valid = (count_reg != '0);
    assign flush_any = flush | global_flush;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign op        = decode_op(push, pop);
    assign count     = count_reg;

    // Head fields are gated so decode sees a NOP with PC 0 when empty.
    assign pc_out     = out_valid ? pc_mem[rd_ptr_reg]     : '0;
    assign inst_out   = out_valid ? inst_mem[rd_ptr_reg]   : '0;
    assign bubble_out = out_valid ? bubble_mem[rd_ptr_reg] : 1'b0;

    // Pointer and occupancy state. Flush wins over any concurrent push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush_any) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            case (op)
                OP_PUSH: begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                    count_reg  <= count_reg + CNT_ONE;
                end
                OP_POP: begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                    count_reg  <= count_reg - CNT_ONE;
                end
                OP_BOTH: begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                    rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    // Entry write; suppressed on flush so a discarded push leaves no trace.
    always_ff @(posedge clk) begin
        if (push && !flush_any) begin
            pc_mem[wr_ptr_reg]     <= pc_in;
            inst_mem[wr_ptr_reg]   <= inst_in;
            bubble_mem[wr_ptr_reg] <= bubble_in;
        end
    end

endmodule

// File: tb/tb_pipeline_fetch_queue.sv
module tb_pipeline_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        global_flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc_in;
    logic [31:0] inst_in;
    logic        bubble_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        bubble_out;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_fetch_queue #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .global_flush(global_flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .pc_in(pc_in),
        .inst_in(inst_in),
        .bubble_in(bubble_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .pc_out(pc_out),
        .inst_out(inst_out),
        .bubble_out(bubble_out),
        .count(count)
    );

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        flush        = 1'b0;
        global_flush = 1'b0;
        bubble_in    = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] inst, input logic bub);
        in_valid  = 1'b1;
        pc_in     = pc;
        inst_in   = inst;
        bubble_in = bub;
        step();
        in_valid  = 1'b0;
        bubble_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        pc_in = '0;
        inst_in = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) push_one(32'h200 + 32'(4*i), 32'(i+1), 1'b0);
        checks++;
        if (count !== 3'd3) begin errors++; $display("FAIL reset_prefill_count got=%0d exp=3", count); end
        // Assert reset between edges: outputs must clear without a clock.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_async_ctrl count=%0d out_valid=%b in_ready=%b exp 0/0/1", count, out_valid, in_ready);
        end
        checks++;
        if (pc_out !== 32'h0 || inst_out !== 32'h0 || bubble_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_data pc=%h inst=%h bub=%b exp 0/0/0", pc_out, inst_out, bubble_out);
        end
        step();
        rst_n = 1'b1;
        in_valid = 1'b1;
        pc_in = 32'h100;
        inst_in = 32'h2008_0005;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_bypass out_valid=%b exp 0", out_valid); end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || pc_out !== 32'h100 || inst_out !== 32'h2008_0005) begin
            errors++;
            $display("FAIL reset_first_push valid=%b pc=%h inst=%h exp 1/00000100/20080005", out_valid, pc_out, inst_out);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL reset_drain count=%0d exp 0", count); end
        $display("test_reset done");
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) push_one(32'(4*i), 32'hA000 + 32'(i), 1'b0);
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full count=%0d in_ready=%b exp 4/0", count, in_ready);
        end
        push_one(32'h10, 32'hDEAD, 1'b0);
        checks++;
        if (count !== 3'd4 || pc_out !== 32'h0) begin
            errors++;
            $display("FAIL fill_fifth_rejected count=%0d head=%h exp 4/00000000", count, pc_out);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pc_out !== 32'(4*i) || inst_out !== 32'hA000 + 32'(i)) begin
                errors++;
                $display("FAIL drain_order[%0d] pc=%h inst=%h exp %h/%h", i, pc_out, inst_out, 32'(4*i), 32'hA000 + 32'(i));
            end
            step();
        end
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty count=%0d out_valid=%b exp 0/0", count, out_valid);
        end
        $display("test_fill_drain done");
    endtask

    task automatic test_back_to_back();
        push_one(32'h1000, 32'h1, 1'b0);
        push_one(32'h1004, 32'h2, 1'b0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc_in = 32'h1008 + 32'(4*i);
            inst_in = 32'(i+3);
            #1;
            checks++;
            if (pc_out !== 32'h1000 + 32'(4*i) || count !== 3'd2) begin
                errors++;
                $display("FAIL b2b[%0d] pc=%h count=%0d exp %h/2", i, pc_out, count, 32'h1000 + 32'(4*i));
            end
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (pc_out !== 32'h1028 + 32'(4*i)) begin
                errors++;
                $display("FAIL b2b_tail[%0d] pc=%h exp %h", i, pc_out, 32'h1028 + 32'(4*i));
            end
            step();
        end
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL b2b_empty count=%0d exp 0", count); end
        $display("test_back_to_back done");
    endtask

    task automatic test_full_pushpop();
        for (int i = 0; i < 4; i++) push_one(32'h300 + 32'(4*i), 32'(i), 1'b0);
        in_valid = 1'b1;
        pc_in = 32'h400;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd3 || in_ready !== 1'b1 || pc_out !== 32'h304) begin
            errors++;
            $display("FAIL full_pushpop count=%0d in_ready=%b head=%h exp 3/1/00000304", count, in_ready, pc_out);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (pc_out !== 32'h300 + 32'(4*i)) begin
                errors++;
                $display("FAIL full_pushpop_drain[%0d] pc=%h exp %h", i, pc_out, 32'h300 + 32'(4*i));
            end
            step();
        end
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL full_pushpop_nopush count=%0d exp 0", count); end
        $display("test_full_pushpop done");
    endtask

    task automatic test_flush(input logic use_global);
        for (int i = 0; i < 3; i++) push_one(32'h500 + 32'(4*i), 32'hB0 + 32'(i), 1'b0);
        in_valid = 1'b1;
        pc_in = 32'h600;
        inst_in = 32'hBAD;
        out_ready = 1'b1;
        if (use_global) global_flush = 1'b1; else flush = 1'b1;
        step();
        idle();
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || inst_out !== 32'h0 || pc_out !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush(global=%b) count=%0d valid=%b inst=%h pc=%h in_ready=%b exp 0/0/0/0/1",
                     use_global, count, out_valid, inst_out, pc_out, in_ready);
        end
        push_one(32'h700, 32'hC0, 1'b0);
        checks++;
        if (count !== 3'd1 || pc_out !== 32'h700 || inst_out !== 32'hC0) begin
            errors++;
            $display("FAIL flush_refill(global=%b) count=%0d pc=%h inst=%h exp 1/00000700/000000c0",
                     use_global, count, pc_out, inst_out);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        $display("test_flush global=%b done", use_global);
    endtask

    task automatic test_bubble();
        logic exp_bub [3];
        exp_bub[0] = 1'b0;
        exp_bub[1] = 1'b1;
        exp_bub[2] = 1'b0;
        push_one(32'h3C, 32'h11, 1'b0);
        push_one(32'h40, 32'h0, 1'b1);
        push_one(32'h44, 32'h22, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pc_out !== 32'h3C + 32'(4*i) || bubble_out !== exp_bub[i]) begin
                errors++;
                $display("FAIL bubble[%0d] pc=%h bub=%b exp %h/%b", i, pc_out, bubble_out, 32'h3C + 32'(4*i), exp_bub[i]);
            end
            step();
        end
        out_ready = 1'b0;
        checks++;
        if (bubble_out !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bubble_empty bub=%b valid=%b exp 0/0", bubble_out, out_valid);
        end
        $display("test_bubble done");
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_full_pushpop();
        test_flush(1'b0);
        test_flush(1'b1);
        test_bubble();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
